// File: rtl/rgbw_pwm_engine.sv
// rgbw_pwm_engine: four-channel (R,G,B,W) PWM with double-buffered 8-bit duties, advancing on a prescaled tick.
// Optional feature macro RGBW_PWM_PHASE_STAGGER_EN offsets channel N's phase by N*PHASE_OFS ticks.
module rgbw_pwm_engine #(
    parameter int DUTY_W    = 8,
    parameter int PHASE_OFS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_half,
    input  logic              pwm_en,
    input  logic              duty_ld,
    input  logic [DUTY_W-1:0] duty0,
    input  logic [DUTY_W-1:0] duty1,
    input  logic [DUTY_W-1:0] duty2,
    input  logic [DUTY_W-1:0] duty3,
    output logic              d0,
    output logic              d1,
    output logic              d2,
    output logic              d3,
    output logic              upd_pending,
    output logic              period_strb
);

    localparam int                NUM_CH   = 4;
    localparam int                PERIOD   = (1 << DUTY_W) - 1;
    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD - 1);
    localparam logic [DUTY_W:0]   PERIOD_X = (DUTY_W + 1)'(PERIOD);
`ifdef RGBW_PWM_PHASE_STAGGER_EN
    localparam int                STAGGER  = 1;
`else
    localparam int                STAGGER  = 0;
`endif

    logic [DUTY_W-1:0] r_cnt;
    logic              r_restart;
    logic              r_pending;
    logic              r_strb;
    logic              w_tick;
    logic              w_boundary;
    logic [DUTY_W-1:0] w_duty_in [NUM_CH];
    logic [NUM_CH-1:0] w_pwm;

    assign w_duty_in[0] = duty0;
    assign w_duty_in[1] = duty1;
    assign w_duty_in[2] = duty2;
    assign w_duty_in[3] = duty3;

    // The first tick after (re)enable is treated as a wrap so pending duties apply immediately.
    assign w_tick     = clk_half & pwm_en;
    assign w_boundary = w_tick & (r_restart | (r_cnt == CNT_LAST));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_restart <= 1'b0;
        end else if (!pwm_en) begin
            r_cnt     <= '0;
            r_restart <= 1'b1;
        end else if (w_boundary) begin
            r_cnt     <= '0;
            r_restart <= 1'b0;
        end else if (w_tick) begin
            r_cnt     <= r_cnt + DUTY_W'(1);
        end
    end

    // A load coinciding with the boundary bypasses the shadow, so pending never rises for it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pending <= 1'b0;
            r_strb    <= 1'b0;
        end else begin
            r_strb <= w_boundary;
            if (w_boundary) begin
                r_pending <= 1'b0;
            end else if (duty_ld) begin
                r_pending <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam int OFS = STAGGER * ((gi * PHASE_OFS) % PERIOD);

            logic [DUTY_W-1:0] r_shadow;
            logic [DUTY_W-1:0] r_active;
            logic              r_pwm;
            logic [DUTY_W:0]   w_sum;
            logic              w_wrap;
            logic [DUTY_W-1:0] w_phase;

            // (cnt + OFS) mod PERIOD: subtracting 2^W-1 equals dropping the carry and adding 1.
            assign w_sum   = {1'b0, r_cnt} + (DUTY_W + 1)'(OFS);
            assign w_wrap  = (w_sum >= PERIOD_X);
            assign w_phase = w_sum[DUTY_W-1:0] + DUTY_W'(w_wrap);

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_shadow <= '0;
                    r_active <= '0;
                    r_pwm    <= 1'b0;
                end else begin
                    if (duty_ld) begin
                        r_shadow <= w_duty_in[gi];
                    end
                    if (w_boundary && duty_ld) begin
                        r_active <= w_duty_in[gi];
                    end else if (w_boundary && r_pending) begin
                        r_active <= r_shadow;
                    end
                    r_pwm <= pwm_en & (w_phase < r_active);
                end
            end

            assign w_pwm[gi] = r_pwm;
        end
    endgenerate

    assign d0          = w_pwm[0];
    assign d1          = w_pwm[1];
    assign d2          = w_pwm[2];
    assign d3          = w_pwm[3];
    assign upd_pending = r_pending;
    assign period_strb = r_strb;

endmodule

// File: tb/tb_rgbw_pwm_engine.sv
// Self-checking bench for rgbw_pwm_engine: period-level reference model of duty double-buffering,
// high-time per period, enable/prescale behaviour and (optional) phase stagger.
`timescale 1ns/1ps
module tb_rgbw_pwm_engine;

    localparam int PERIOD = 255;
    localparam int OFS    = 64;
`ifdef RGBW_PWM_PHASE_STAGGER_EN
    localparam bit STAGGER = 1'b1;
`else
    localparam bit STAGGER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_half;
    logic       pwm_en;
    logic       duty_ld;
    logic [7:0] duty0, duty1, duty2, duty3;
    logic       d0, d1, d2, d3;
    logic       upd_pending;
    logic       period_strb;
    logic [3:0] d_vec;

    int n_cmp = 0;
    int n_bad = 0;
    int half_div = 1;
    int half_cnt = 0;

    // reference model: duties per period
    int m_active [4];
    int m_shadow [4];
    bit m_pending;

    // results of the last run_period
    int hi_cnt  [4];
    int rise_at [4];
    int per_len;
    int pend_bad;
    bit pend_seen;
    bit per_to;

    rgbw_pwm_engine dut (
        .clk         (clk),
        .reset       (reset),
        .clk_half    (clk_half),
        .pwm_en      (pwm_en),
        .duty_ld     (duty_ld),
        .duty0       (duty0),
        .duty1       (duty1),
        .duty2       (duty2),
        .duty3       (duty3),
        .d0          (d0),
        .d1          (d1),
        .d2          (d2),
        .d3          (d3),
        .upd_pending (upd_pending),
        .period_strb (period_strb)
    );

    assign d_vec = {d3, d2, d1, d0};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        half_cnt = (half_cnt + 1) % half_div;
        clk_half = (half_cnt == 0);
    endtask

    task automatic set_duties(input logic [31:0] v);
        duty0 = v[7:0];
        duty1 = v[15:8];
        duty2 = v[23:16];
        duty3 = v[31:24];
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            m_active[n] = 0;
            m_shadow[n] = 0;
        end
        m_pending = 1'b0;
    endtask

    task automatic model_load(input logic [31:0] v);
        for (int n = 0; n < 4; n++) m_shadow[n] = int'(v[8*n +: 8]);
        m_pending = 1'b1;
    endtask

    task automatic model_boundary(input bit ld, input logic [31:0] v);
        if (ld) begin
            for (int n = 0; n < 4; n++) begin
                m_shadow[n] = int'(v[8*n +: 8]);
                m_active[n] = int'(v[8*n +: 8]);
            end
            m_pending = 1'b0;
        end else if (m_pending) begin
            for (int n = 0; n < 4; n++) m_active[n] = m_shadow[n];
            m_pending = 1'b0;
        end
    endtask

    task automatic wait_strb(input int max_clk, output bit to);
        int k = 0;
        do begin
            step();
            k++;
        end while (period_strb !== 1'b1 && k < max_clk);
        to = (period_strb !== 1'b1);
    endtask

    // Runs from the current sample up to and including the next period_strb sample,
    // optionally pulsing duty_ld before clk index ld_a / ld_b (1-based), and gathers statistics.
    task automatic run_period(input int ld_a, input logic [31:0] va,
                              input int ld_b, input logic [31:0] vb);
        int i = 0;
        bit ld;
        logic [31:0] v;
        for (int n = 0; n < 4; n++) begin
            hi_cnt[n]  = 0;
            rise_at[n] = -1;
        end
        per_len = 0; pend_bad = 0; pend_seen = 1'b0; per_to = 1'b0;
        forever begin
            i++;
            ld = (i == ld_a) || (i == ld_b);
            v  = (i == ld_a) ? va : vb;
            if (ld) begin
                duty_ld = 1'b1;
                set_duties(v);
            end
            step();
            duty_ld = 1'b0;
            per_len++;
            for (int n = 0; n < 4; n++) begin
                if (d_vec[n] === 1'b1) begin
                    hi_cnt[n]++;
                    if (rise_at[n] < 0) rise_at[n] = i - 1;
                end
            end
            if (period_strb === 1'b1) model_boundary(ld, v);
            else if (ld) model_load(v);
            if (upd_pending !== m_pending) pend_bad++;
            if (upd_pending === 1'b1) pend_seen = 1'b1;
            if (period_strb === 1'b1) break;
            if (i >= PERIOD * half_div + 8) begin
                per_to = 1'b1;
                break;
            end
        end
        $display("period: len=%0d hi=%0d/%0d/%0d/%0d rise=%0d/%0d/%0d/%0d pend_seen=%0b",
                 per_len, hi_cnt[0], hi_cnt[1], hi_cnt[2], hi_cnt[3],
                 rise_at[0], rise_at[1], rise_at[2], rise_at[3], pend_seen);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pwm_en   = 1'($urandom);
            duty_ld  = 1'($urandom);
            clk_half = 1'($urandom);
            set_duties($urandom);
            @(posedge clk);
            #1;
            n_cmp++;
            if ({d_vec, upd_pending, period_strb} !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_outputs cyc%0d: d=%b upd_pending=%b period_strb=%b, expected all 0",
                         k, d_vec, upd_pending, period_strb);
            end
        end
        reset = 1'b1; duty_ld = 1'b0; pwm_en = 1'b1;
        half_div = 1; half_cnt = 0; clk_half = 1'b1;
        model_reset();
    endtask

    task automatic test_duty_patterns();
        int exp_hi [4];
        for (int n = 0; n < 4; n++) exp_hi[n] = m_active[n] * half_div;
        run_period(20, 32'hFF80_0100, 0, 32'h0);
        n_cmp++;
        if (per_to || per_len !== PERIOD) begin
            n_bad++;
            $display("FAIL first_period_len: %0d clks (timeout=%0b), expected %0d", per_len, per_to, PERIOD);
        end
        n_cmp++;
        if (pend_seen !== 1'b1 || pend_bad !== 0) begin
            n_bad++;
            $display("FAIL pending_until_wrap: seen=%0b mistracked=%0d, expected seen=1 mistracked=0", pend_seen, pend_bad);
        end
        for (int n = 0; n < 4; n++) begin
            n_cmp++;
            if (hi_cnt[n] !== exp_hi[n]) begin
                n_bad++;
                $display("FAIL first_period_hi ch%0d: %0d, expected %0d", n, hi_cnt[n], exp_hi[n]);
            end
        end
        for (int n = 0; n < 4; n++) exp_hi[n] = m_active[n] * half_div;
        run_period(0, 32'h0, 0, 32'h0);
        for (int n = 0; n < 4; n++) begin
            n_cmp++;
            if (hi_cnt[n] !== exp_hi[n]) begin
                n_bad++;
                $display("FAIL duty_pattern_hi ch%0d: %0d, expected %0d", n, hi_cnt[n], exp_hi[n]);
            end
        end
    endtask

    task automatic test_reload_midperiod();
        int exp_hi [4];
        for (int n = 0; n < 4; n++) exp_hi[n] = m_active[n];
        run_period(40, {4{8'd64}}, 200, {4{8'd200}});
        for (int n = 0; n < 4; n++) begin
            n_cmp++;
            if (hi_cnt[n] !== exp_hi[n]) begin
                n_bad++;
                $display("FAIL reload_old_kept ch%0d: %0d, expected %0d", n, hi_cnt[n], exp_hi[n]);
            end
        end
        n_cmp++;
        if (pend_bad !== 0) begin
            n_bad++;
            $display("FAIL reload_pending: mistracked %0d clks, expected 0", pend_bad);
        end
        run_period(0, 32'h0, 0, 32'h0);
        for (int n = 0; n < 4; n++) begin
            n_cmp++;
            if (hi_cnt[n] !== 200) begin
                n_bad++;
                $display("FAIL reload_last_wins ch%0d: %0d, expected 200", n, hi_cnt[n]);
            end
        end
    endtask

    task automatic test_ld_on_wrap();
        int exp_hi [4];
        for (int n = 0; n < 4; n++) exp_hi[n] = m_active[n];
        run_period(PERIOD, {4{8'd100}}, 0, 32'h0);
        n_cmp++;
        if (pend_seen !== 1'b0 || pend_bad !== 0) begin
            n_bad++;
            $display("FAIL wrap_load_pending: seen=%0b mistracked=%0d, expected seen=0", pend_seen, pend_bad);
        end
        for (int n = 0; n < 4; n++) begin
            n_cmp++;
            if (hi_cnt[n] !== exp_hi[n]) begin
                n_bad++;
                $display("FAIL wrap_load_prev ch%0d: %0d, expected %0d", n, hi_cnt[n], exp_hi[n]);
            end
        end
        run_period(0, 32'h0, 0, 32'h0);
        for (int n = 0; n < 4; n++) begin
            n_cmp++;
            if (hi_cnt[n] !== 100) begin
                n_bad++;
                $display("FAIL wrap_load_hi ch%0d: %0d, expected 100", n, hi_cnt[n]);
            end
        end
    endtask

    task automatic test_random_loads();
        int exp_hi [4];
        int la, lb;
        logic [31:0] va, vb;
        for (int r = 0; r < 6; r++) begin
            for (int n = 0; n < 4; n++) exp_hi[n] = m_active[n];
            la = $urandom_range(1, 250);
            lb = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 250) : 0;
            va = $urandom;
            vb = $urandom;
            run_period(la, va, lb, vb);
            n_cmp++;
            if (per_to || per_len !== PERIOD || pend_bad !== 0) begin
                n_bad++;
                $display("FAIL random_period%0d: len=%0d timeout=%0b pend_mistracked=%0d, expected len=%0d",
                         r, per_len, per_to, pend_bad, PERIOD);
            end
            for (int n = 0; n < 4; n++) begin
                n_cmp++;
                if (hi_cnt[n] !== exp_hi[n]) begin
                    n_bad++;
                    $display("FAIL random_hi p%0d ch%0d: %0d, expected %0d", r, n, hi_cnt[n], exp_hi[n]);
                end
            end
        end
    endtask

    task automatic test_prescale_disable();
        int exp_hi [4];
        bit to;
        logic [31:0] v;
        half_div = 4; half_cnt = 0; clk_half = 1'b1;
        v = {8'hFF, 8'($urandom), 8'($urandom), 8'd10};
        run_period(8, v, 0, 32'h0);
        for (int n = 0; n < 4; n++) exp_hi[n] = m_active[n] * half_div;
        run_period(0, 32'h0, 0, 32'h0);
        n_cmp++;
        if (per_to || per_len !== PERIOD * 4) begin
            n_bad++;
            $display("FAIL prescale_len: %0d clks (timeout=%0b), expected %0d", per_len, per_to, PERIOD * 4);
        end
        for (int n = 0; n < 4; n++) begin
            n_cmp++;
            if (hi_cnt[n] !== exp_hi[n]) begin
                n_bad++;
                $display("FAIL prescale_hi ch%0d: %0d, expected %0d", n, hi_cnt[n], exp_hi[n]);
            end
        end
        for (int k = 0; k < 9; k++) step();
        n_cmp++;
        if (d0 !== 1'b1 || d3 !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_disable_high: d0=%b d3=%b, expected 1 1", d0, d3);
        end
        pwm_en = 1'b0;
        step();
        n_cmp++;
        if (d_vec !== 4'b0 || period_strb !== 1'b0) begin
            n_bad++;
            $display("FAIL disable_low: d=%b period_strb=%b, expected 0000 0", d_vec, period_strb);
        end
        v = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(1, 254))};
        duty_ld = 1'b1;
        set_duties(v);
        step();
        duty_ld = 1'b0;
        model_load(v);
        n_cmp++;
        if (upd_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL load_while_disabled: upd_pending=%b, expected 1", upd_pending);
        end
        for (int k = 0; k < 6; k++) step();
        n_cmp++;
        if (d_vec !== 4'b0 || upd_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL disabled_hold: d=%b upd_pending=%b, expected 0000 1", d_vec, upd_pending);
        end
        pwm_en = 1'b1;
        wait_strb(16, to);
        model_boundary(1'b0, 32'h0);
        n_cmp++;
        if (to || upd_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL reenable_strb: timeout=%0b upd_pending=%b, expected strobe with pending 0", to, upd_pending);
        end
        for (int n = 0; n < 4; n++) exp_hi[n] = m_active[n] * half_div;
        run_period(0, 32'h0, 0, 32'h0);
        n_cmp++;
        if (per_to || per_len !== PERIOD * 4) begin
            n_bad++;
            $display("FAIL reenable_len: %0d clks, expected %0d", per_len, PERIOD * 4);
        end
        for (int n = 0; n < 4; n++) begin
            n_cmp++;
            if (hi_cnt[n] !== exp_hi[n]) begin
                n_bad++;
                $display("FAIL reenable_hi ch%0d: %0d, expected %0d", n, hi_cnt[n], exp_hi[n]);
            end
        end
    endtask

    task automatic test_phase_stagger();
        int lag, exp_lag;
        half_div = 1; half_cnt = 0; clk_half = 1'b1;
        run_period(5, {4{8'd32}}, 0, 32'h0);
        run_period(0, 32'h0, 0, 32'h0);
        n_cmp++;
        if (rise_at[0] !== 0) begin
            n_bad++;
            $display("FAIL stagger_d0_rise: tick %0d, expected 0", rise_at[0]);
        end
        for (int n = 0; n < 4; n++) begin
            lag     = (rise_at[n] - rise_at[0] + PERIOD) % PERIOD;
            exp_lag = STAGGER ? (PERIOD - (n * OFS) % PERIOD) % PERIOD : 0;
            n_cmp++;
            if (rise_at[n] < 0 || lag !== exp_lag || hi_cnt[n] !== 32) begin
                n_bad++;
                $display("FAIL stagger_ch%0d: lag %0d hi %0d, expected lag %0d hi 32", n, lag, hi_cnt[n], exp_lag);
            end
        end
    endtask

    task automatic test_reset_midperiod();
        for (int k = 0; k < 30; k++) begin
            if (k == 10) begin
                duty_ld = 1'b1;
                set_duties($urandom);
            end
            step();
            duty_ld = 1'b0;
        end
        n_cmp++;
        if (upd_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL pending_before_reset: upd_pending=%b, expected 1", upd_pending);
        end
        reset = 1'b0;
        step();
        n_cmp++;
        if ({d_vec, upd_pending, period_strb} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_mid: d=%b upd_pending=%b period_strb=%b, expected all 0", d_vec, upd_pending, period_strb);
        end
        reset = 1'b1;
        model_reset();
        run_period(0, 32'h0, 0, 32'h0);
        n_cmp++;
        if (per_to || per_len !== PERIOD || pend_bad !== 0) begin
            n_bad++;
            $display("FAIL post_reset_len: %0d clks pend_mistracked=%0d, expected %0d", per_len, pend_bad, PERIOD);
        end
        for (int n = 0; n < 4; n++) begin
            n_cmp++;
            if (hi_cnt[n] !== 0) begin
                n_bad++;
                $display("FAIL post_reset_hi ch%0d: %0d, expected 0", n, hi_cnt[n]);
            end
        end
    endtask

    initial begin
        reset = 1'b0; clk_half = 1'b0; pwm_en = 1'b0; duty_ld = 1'b0;
        set_duties(32'h0);
        model_reset();
        test_reset();
        test_duty_patterns();
        test_reload_midperiod();
        test_ld_on_wrap();
        test_random_loads();
        test_prescale_disable();
        test_phase_stagger();
        test_reset_midperiod();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
